uart_rx: RTL and testbench

Serial receive front end of the UART peripheral. Samples the asynchronous rxd line, detects and validates start bits, and deserializes 8N1/8N2 frames LSB-first at the baud rate set by the divisor register. Delivers one byte per frame with a single-cycle valid strobe to the UART's receive FIFO, and flags framing errors. Sits directly upstream of the RX FIFO / rxdata register of the Wishbone UART.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_sync_2ff.sv | 38 +++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART constants and the receive state encoding. Kept in one place so
// the transmit side can reuse the same frame width and encoding style.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Data bits per frame; fixed for this peripheral.
  localparam int DATA_BITS = 8;

  // Receive state encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so idle-high lines (such as a UART rxd) come out of reset idle.
//
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - asynchronous input
//   o_q     - synchronized output (2-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking (<=) so each flop samples its pre-edge input; blocking
  // assignments here would collapse the two stages into one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receive front end. Synchronizes rxd, validates the start bit at its
// midpoint, deserializes 8 data bits LSB-first at (div+1) clocks per bit and
// checks one or two stop bits. Produces a one-cycle valid strobe with the byte
// or a one-cycle framing-error strobe. After a framing error the receiver waits
// for the line to return high so a held-low line cannot retrigger.
//
// Ports:
//   clock         - system clock, rising edge
//   reset_n       - asynchronous active-low reset
//   rxd           - raw serial input, idle high
//   rxen          - receive enable; dropping it aborts a frame in progress
//   nstop         - 0: one stop bit, 1: two stop bits
//   div           - baud divisor (bit period = div+1 clocks), latched per frame
//   rx_data       - last good byte, held until the next good frame
//   rx_data_valid - one-cycle strobe: new byte on rx_data
//   frame_error   - one-cycle strobe: a stop bit sampled low
//   busy          - high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rxd,
  input  logic                 rxen,
  input  logic                 nstop,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  logic                 w_rxd_s;
  logic                 w_tick;

  rx_state_e            r_state,     w_state_nxt;
  logic [DIV_WIDTH-1:0] r_cnt,       w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_div_q,     w_div_q_nxt;
  logic [IDX_W-1:0]     r_bit_idx,   w_bit_idx_nxt;
  logic                 r_stop_idx,  w_stop_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
  logic [DATA_BITS-1:0] r_rx_data,   w_rx_data_nxt;
  logic                 r_valid,     w_valid_nxt;
  logic                 r_ferr,      w_ferr_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rxd (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (rxd),
    .o_q     (w_rxd_s)
  );

  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_div_q    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_q    <= w_div_q_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_valid    <= w_valid_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_q_nxt    = r_div_q;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_rx_data_nxt  = r_rx_data;
    w_valid_nxt    = 1'b0;
    w_ferr_nxt     = 1'b0;

    // Bit timer runs whenever a frame is in progress; reload on tick.
    if (r_state != ST_IDLE) begin
      w_cnt_nxt = w_tick ? r_div_q : r_cnt - 1'b1;
    end

    if (!rxen && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Half-period first wait puts every later sample mid-bit.
          if (rxen && !w_rxd_s) begin
            w_state_nxt = ST_START;
            w_cnt_nxt   = div >> 1;
            w_div_q_nxt = div;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (!w_rxd_s) begin
              w_state_nxt   = ST_DATA;
              w_bit_idx_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            w_shift_nxt   = {w_rxd_s, r_shift[DATA_BITS-1:1]};
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
              w_state_nxt    = ST_STOP;
              w_stop_idx_nxt = 1'b0;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (!w_rxd_s) begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = ST_BREAK;
            end else if (nstop && !r_stop_idx) begin
              w_stop_idx_nxt = 1'b1;
            end else begin
              w_rx_data_nxt = r_shift;
              w_valid_nxt   = 1'b1;
              w_state_nxt   = ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          if (w_rxd_s) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_valid;
  assign frame_error   = r_ferr;
  assign busy          = (r_state != ST_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed and randomized frames driven onto rxd at a chosen line rate. The
// expected byte is the byte that was put on the line; the expected strobe
// time is derived from the serial timing rules (start detect ~2 cycles after
// the falling edge, mid-bit sampling, one cycle of strobe registration).
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rxd;
  logic        rxen;
  logic        nstop;
  logic [15:0] div;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        frame_error;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int unsigned t0     = 0;

  // Strobe log filled by the monitor.
  logic [7:0]  vq_data[$];
  int unsigned vq_cyc[$];
  int unsigned fq_cyc[$];

  uart_rx #(.DIV_WIDTH(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rxd           (rxd),
    .rxen          (rxen),
    .nstop         (nstop),
    .div           (div),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && (rx_data_valid || frame_error)) begin
      check("strobe_exclusive", 32'(rx_data_valid && frame_error), 32'd0);
      if (rx_data_valid) begin
        vq_data.push_back(rx_data);
        vq_cyc.push_back(cyc);
      end
      if (frame_error) fq_cyc.push_back(cyc);
    end
  end

  // Cycles from the falling start edge to the visible strobe.
  function automatic int unsigned spec_latency(input int unsigned d, input bit two_stop);
    return 2 + d / 2 + 9 * (d + 1) + (two_stop ? d + 1 : 0) + 1;
  endfunction

  function automatic logic in_window(input int unsigned lat, input int unsigned exp);
    return (lat + 2 >= exp) && (lat <= exp + 2);
  endfunction

  task automatic clear_log();
    vq_data.delete();
    vq_cyc.delete();
    fq_cyc.delete();
  endtask

  task automatic line_bit(input logic b, input int unsigned d);
    rxd = b;
    repeat (d + 1) @(negedge clock);
  endtask

  // hook_kind 1: drop rxen mid data bit hook_bit; 2: change div to new_div.
  task automatic send_frame(input logic [7:0] b, input int unsigned d, input bit two_stop,
                            input logic last_stop, input int hook_bit, input int hook_kind,
                            input logic [15:0] new_div);
    int unsigned half;
    half = (d + 1) / 2;
    t0 = cyc;
    line_bit(1'b0, d);
    for (int i = 0; i < 8; i++) begin
      if (i == hook_bit) begin
        rxd = b[i];
        repeat (half) @(negedge clock);
        if (hook_kind == 1) rxen = 1'b0;
        else div = new_div;
        @(negedge clock);
        if (hook_kind == 1) check("abort_busy", 32'(busy), 32'd0);
        repeat (d + 1 - half - 1) @(negedge clock);
      end else begin
        line_bit(b[i], d);
      end
    end
    if (two_stop) line_bit(1'b1, d);
    line_bit(last_stop, d);
  endtask

  task automatic expect_frame(input logic [7:0] b, input int unsigned d, input bit two_stop);
    check("n_valid", 32'(vq_data.size()), 32'd1);
    if (vq_data.size() >= 1) begin
      check("rx_byte", 32'(vq_data[0]), 32'(b));
      check("valid_time", 32'(in_window(vq_cyc[0] - t0, spec_latency(d, two_stop))), 32'd1);
    end
    check("n_ferr", 32'(fq_cyc.size()), 32'd0);
    check("rx_data_held", 32'(rx_data), 32'(b));
    check("busy_after", 32'(busy), 32'd0);
    clear_log();
  endtask

  initial begin
    reset_n = 1'b0;
    rxd     = 1'b1;
    rxen    = 1'b1;
    nstop   = 1'b0;
    div     = 16'd99;

    // Reset with the line toggling.
    for (int i = 0; i < 8; i++) begin
      rxd = i[0];
      @(negedge clock);
    end
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_data_valid), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rxd = 1'b1;
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single 8N1 frame.
    send_frame(8'hA5, 99, 1'b0, 1'b1, -1, 0, 16'd0);
    expect_frame(8'hA5, 99, 1'b0);
    repeat (20) @(negedge clock);

    // 20-cycle low glitch on the idle line.
    t0 = cyc;
    rxd = 1'b0;
    repeat (10) @(negedge clock);
    check("glitch_detect", 32'(busy), 32'd1);
    repeat (10) @(negedge clock);
    rxd = 1'b1;
    repeat (36) @(negedge clock);
    check("glitch_rejected", 32'(busy), 32'd0);
    repeat (100) @(negedge clock);
    check("glitch_no_valid", 32'(vq_data.size()), 32'd0);
    check("glitch_no_ferr", 32'(fq_cyc.size()), 32'd0);
    clear_log();

    // Two stop bits, back-to-back frames, then a bad second stop bit.
    nstop = 1'b1;
    repeat (5) @(negedge clock);
    send_frame(8'h00, 99, 1'b1, 1'b1, -1, 0, 16'd0);
    expect_frame(8'h00, 99, 1'b1);
    send_frame(8'hFF, 99, 1'b1, 1'b1, -1, 0, 16'd0);
    expect_frame(8'hFF, 99, 1'b1);
    send_frame(8'h81, 99, 1'b1, 1'b0, -1, 0, 16'd0);
    check("ferr_count", 32'(fq_cyc.size()), 32'd1);
    if (fq_cyc.size() >= 1)
      check("ferr_time", 32'(in_window(fq_cyc[0] - t0, spec_latency(99, 1'b1))), 32'd1);
    check("ferr_no_valid", 32'(vq_data.size()), 32'd0);
    check("ferr_rx_data", 32'(rx_data), 32'hFF);
    check("break_busy", 32'(busy), 32'd1);
    repeat (300) @(negedge clock);
    check("break_hold_busy", 32'(busy), 32'd1);
    check("break_no_retrig", 32'(vq_data.size() + fq_cyc.size()), 32'd1);
    rxd = 1'b1;
    repeat (5) @(negedge clock);
    check("break_exit", 32'(busy), 32'd0);
    clear_log();

    // rxen dropped mid data, then a clean frame.
    nstop = 1'b0;
    repeat (5) @(negedge clock);
    send_frame(8'h3C, 99, 1'b0, 1'b1, 3, 1, 16'd0);
    check("abort_no_valid", 32'(vq_data.size()), 32'd0);
    check("abort_no_ferr", 32'(fq_cyc.size()), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'hFF);
    rxen = 1'b1;
    repeat (20) @(negedge clock);
    send_frame(8'hC3, 99, 1'b0, 1'b1, -1, 0, 16'd0);
    expect_frame(8'hC3, 99, 1'b0);

    // Divisor change mid-frame applies from the next frame.
    repeat (10) @(negedge clock);
    send_frame(8'h5A, 99, 1'b0, 1'b1, 4, 2, 16'd49);
    expect_frame(8'h5A, 99, 1'b0);
    repeat (10) @(negedge clock);
    send_frame(8'h12, 49, 1'b0, 1'b1, -1, 0, 16'd0);
    expect_frame(8'h12, 49, 1'b0);

    // Randomized frames at random rates and stop-bit counts.
    for (int k = 0; k < 6; k++) begin
      int unsigned d;
      logic [7:0]  b;
      bit          ts;
      d     = $urandom_range(60, 15);
      ts    = 1'($urandom_range(1, 0));
      b     = 8'($urandom);
      div   = 16'(d);
      nstop = ts;
      repeat (5) @(negedge clock);
      send_frame(b, d, ts, 1'b1, -1, 0, 16'd0);
      expect_frame(b, d, ts);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx
